// File: rtl/cell_pos_reader_pkg.sv
// cell_pos_reader_pkg: shared FSM states, position-word field layout and header address.
package cell_pos_reader_pkg;
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_HWAIT, S_STREAM, S_DRAIN, S_DONE} state_t;
  localparam int POS_W = 32;
  localparam int POSX_LSB = 0;
  localparam int POSY_LSB = 32;
  localparam int POSZ_LSB = 64;
  localparam int HDR_ADDR = 0;
endpackage

// File: rtl/cell_pos_fifo.sv
// cell_pos_fifo: show-ahead synchronous FIFO with occupancy count.
module cell_pos_fifo #(
  parameter int WIDTH = 105,
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [CW-1:0]    count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk) if (push) mem[wp] <= din;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp == AW'(DEPTH - 1) ? '0 : wp + 1'b1;
      if (pop) rp <= rp == AW'(DEPTH - 1) ? '0 : rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign dout = mem[rp];
  assign empty = count == '0;
  // upstream credit accounting guarantees this never fires
  assert property (@(posedge clk) disable iff (rst) !(push && !pop && count == CW'(DEPTH)));
endmodule

// File: rtl/cell_pos_reader.sv
// cell_pos_reader: streams one cell's particle positions from cell memory to a valid/ready stream.
// Optional macro CELL_READER_COUNT_CLAMP_EN clamps oversized header counts and flags count_err.
module cell_pos_reader
  import cell_pos_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8,
  parameter int PARTICLE_NUM = 220,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic                  count_err,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_pid,
  output logic                  out_last
);
  localparam int EW = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] addr_n, n_n, p1, p2, hdr_cnt, hdr_val;
  logic rden_n, err_n, v1, v2, hdr_over, push, pop, empty, credit;
  logic [CW-1:0] occ;
  logic [CW+1:0] used;
  logic [EW-1:0] head;
  assign hdr_cnt = mem_q[ADDR_WIDTH-1:0];
`ifdef CELL_READER_COUNT_CLAMP_EN
  localparam logic [ADDR_WIDTH-1:0] MAX_N = ADDR_WIDTH'(PARTICLE_NUM - 1);
  assign hdr_over = hdr_cnt > MAX_N;
  assign hdr_val = hdr_over ? MAX_N : hdr_cnt;
`else
  assign hdr_over = 1'b0;
  assign hdr_val = hdr_cnt;
`endif
  // outstanding = issued-but-not-landed reads plus buffered words, minus the word leaving now
  assign used = (CW+2)'(occ) + (CW+2)'(mem_rden) + (CW+2)'(v1) + (CW+2)'(v2);
  assign credit = used - (CW+2)'(pop) < (CW+2)'(FIFO_DEPTH);
  assign push = v2 && state != S_HWAIT;
  assign pop = out_valid && out_ready;
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  assign mem_wren = 1'b0;
  assign out_valid = !empty;
  assign out_data = out_valid ? head[DATA_WIDTH-1:0] : '0;
  assign out_pid = out_valid ? head[DATA_WIDTH +: ADDR_WIDTH] : '0;
  assign out_last = out_valid && head[EW-1];
  always_comb begin
    state_n = state;
    rden_n = 1'b0;
    addr_n = mem_address;
    n_n = particle_count;
    err_n = count_err;
    case (state)
      S_IDLE: if (start) begin
        state_n = S_HDR;
        rden_n = 1'b1;
        addr_n = ADDR_WIDTH'(HDR_ADDR);
        err_n = 1'b0;
      end
      S_HDR: state_n = S_HWAIT;
      S_HWAIT: if (v2) begin
        n_n = hdr_val;
        err_n = hdr_over;
        rden_n = hdr_val != '0;
        addr_n = ADDR_WIDTH'(1);
        state_n = hdr_val == '0 ? S_DONE : hdr_val == ADDR_WIDTH'(1) ? S_DRAIN : S_STREAM;
      end
      S_STREAM: if (credit) begin
        rden_n = 1'b1;
        addr_n = mem_address + 1'b1;
        state_n = addr_n == particle_count ? S_DRAIN : S_STREAM;
      end
      S_DRAIN: state_n = pop && out_last ? S_DONE : S_DRAIN;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      mem_rden <= 1'b0;
      mem_address <= '0;
      particle_count <= '0;
      count_err <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      p1 <= '0;
      p2 <= '0;
    end else begin
      state <= state_n;
      mem_rden <= rden_n;
      mem_address <= addr_n;
      particle_count <= n_n;
      count_err <= err_n;
      v1 <= mem_rden;
      v2 <= v1;
      p1 <= mem_address;
      p2 <= p1;
    end
  end
  cell_pos_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din({p2 == particle_count, p2, mem_q}),
    .dout(head),
    .empty(empty),
    .count(occ)
  );
endmodule
